rom_burst_reader: RTL
=====================

// Module: rom_burst_reader
// PURPOSE
//  Parametrised successor to the fixed 256x16 single-address ROM: streams a burst of LEN_M1+1
//  consecutive words from a ROM built on SB_RAM40_4K, starting at START_ADDR, wrapping modulo DEPTH.
//  Output uses a valid/ready handshake with full throughput and lossless backpressure. This absorbs
//  the one-cycle BRAM read latency. Sits between table/pattern ROMs and streaming consumers (UART, LED, DAC).
// PARAMETERS
//  WIDTH     16     word width; one of 16/8/4/2 (maps to READ_MODE 0/1/2/3)
//  DEPTH     256    words; power of two, DEPTH*WIDTH <= 4096 (256x16, 512x8, 1024x4, 2048x2)
//  AW        $clog2(DEPTH)  address width (derived, not overridden)
//  INIT_FILE ""     hex image loaded into ROM; empty -> word n holds n (truncated to WIDTH)
// PORTS
//  CLKIN       in   1      clock (ROM RCLK and all logic)
//  RESET       in   1      synchronous, active-high reset
//  START       in   1      request burst; sampled only when BUSY=0
//  START_ADDR  in   AW     first word address
//  LEN_M1      in   AW     burst length minus one (0 -> 1 word, DEPTH-1 -> DEPTH words)
//  BUSY        out  1      burst in progress
//  DONE        out  1      one-cycle pulse: last word of burst accepted
//  RDATA       out  WIDTH  output word
//  RVALID      out  1      RDATA valid
//  RREADY      in   1      consumer accepts RDATA when RVALID&RREADY
// BEHAVIOUR
//  Reset: BUSY=0, DONE=0, RVALID=0, RDATA=0; FSM=IDLE; FIFO, in-flight flag and counters cleared.
//  FSM: IDLE -(START)-> RUN -(all reads issued)-> DRAIN -(last word accepted)-> IDLE.
//   - IDLE: START=1 latches addr<=START_ADDR, remaining<=LEN_M1, BUSY<=1 next cycle.
//   - RUN: issue one ROM read per cycle when credit ok; addr<=addr+1 mod DEPTH; remaining--.
//     After issuing the read with remaining==0 -> DRAIN.
//   - DRAIN: no reads; when final word handshakes -> IDLE, DONE=1 for that cycle following, BUSY=0 same cycle.
//  START while BUSY=1 ignored entirely (no latch, no effect on current burst).
//  ROM: RE=1, RCLKE=1, write port tied off (WE=0, WCLKE=0, MASK/WDATA/WADDR=0).
//  Read issued in cycle n -> ROM data valid cycle n+1 -> written into 2-entry output FIFO at end of n+1.
//  Credit rule: issue iff (fifo_count + inflight - pop) < 2, pop = RVALID&RREADY this cycle.
//   Guarantees FIFO never overflows and no read is ever dropped or duplicated.
//  Latency: START high in cycle 0 -> first read cycle 1 -> RVALID=1 from cycle 3; with RREADY held 1,
//   one word per cycle thereafter, burst of N words ends with last handshake in cycle N+2.
//  RVALID/RDATA stable while RVALID=1 & RREADY=0 (AXI-stream rule); RDATA = FIFO head, 0 when empty.
//  Wrap: addr DEPTH-1 + 1 -> 0; no error, no stall.
//  LEN_M1=DEPTH-1: entire ROM read once, starting address read exactly once.
//  RESET mid-burst: takes priority over everything; in-flight read discarded, FIFO flushed,
//   outputs to reset values next cycle; no DONE pulse for aborted burst.
//  START and RESET same cycle: RESET wins, START lost.
// STRUCTURE
//  Package rom_burst_pkg: READ_MODE lookup function (WIDTH->0..3), FSM state enum
//   {IDLE,RUN,DRAIN}, elaboration check function for legal WIDTH/DEPTH pairs.
//  Sub-module rom_sync_4k: SB_RAM40_4K wrapper, registered read, INIT_0..INIT_F from INIT_FILE
//   or identity pattern; ports CLKIN, RADDR[AW], RDATA[WIDTH] (bit-scatter for narrow modes inside).
//  Top: FSM, address/remaining counters, inflight flag, 2-entry FIFO, credit logic.
// TESTING (WIDTH=16, DEPTH=256, identity image)
//  1 Reset: RESET=1 two cycles -> BUSY=0, DONE=0, RVALID=0, RDATA=0x0000.
//  2 START_ADDR=0x10, LEN_M1=3, RREADY=1 -> RVALID cycles 3..6, RDATA 0x0010..0x0013; DONE cycle 7.
//  3 Backpressure: same burst, RREADY=0 cycles 3..8 then 1 -> RDATA holds 0x0010, no loss/dup;
//    words 0x0010..0x0013 delivered in order; random RREADY over LEN_M1=255 matches 0x00..0xFF.
//  4 Wrap: START_ADDR=0xFE, LEN_M1=3 -> RDATA 0x00FE, 0x00FF, 0x0000, 0x0001.
//  5 START pulsed during burst (START_ADDR=0x80) -> ignored; only original 4 words, single DONE.
//  6 RESET asserted at cycle 4 of LEN_M1=7 burst -> next cycle RVALID=0, BUSY=0, no DONE;
//    fresh START_ADDR=0x20, LEN_M1=0 -> single word 0x0020, DONE once.
//  Repeat test 2 with WIDTH=8, DEPTH=512 (expect 0x10..0x13 truncated identity).

Source files
------------

// File: rtl/rom_burst_pkg.sv
// Shared types and elaboration helpers for the ROM burst reader.
// Holds the FSM state enum, read-mode lookup and ROM image builder.
package rom_burst_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    localparam int ROM_BITS = 4096;
    localparam int BLK_BITS = 256;

    function automatic logic [1:0] read_mode(input int width);
        logic [1:0] m;
        case (width)
            16:      m = 2'd0;
            8:       m = 2'd1;
            4:       m = 2'd2;
            default: m = 2'd3;
        endcase
        return m;
    endfunction

    function automatic bit geometry_ok(input int width, input int depth);
        return (width == 16 && depth == 256)
            || (width == 8  && depth == 512)
            || (width == 4  && depth == 1024)
            || (width == 2  && depth == 2048);
    endfunction

    // Identity image: word n holds n truncated to width, packed LSB-first.
    function automatic logic [ROM_BITS-1:0] rom_image(input int width);
        logic [ROM_BITS-1:0] img;
        int b;
        img = '0;
        for (int blk = 0; blk < ROM_BITS / BLK_BITS; blk++) begin
            for (int i = 0; i < BLK_BITS; i++) begin
                b = blk * BLK_BITS + i;
                img[b] = 1'((b / width) >> (b % width));
            end
        end
        return img;
    endfunction

endpackage

// File: rtl/rom_sync_4k.sv
// 4 kbit block ROM with a registered read port, one word per cycle.
// Contents are the identity image laid out as the sixteen 256-bit INIT blocks.
module rom_sync_4k
    import rom_burst_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 256,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             CLKIN,
    input  logic [AW-1:0]    RADDR,
    output logic [WIDTH-1:0] RDATA
);

    localparam logic [ROM_BITS-1:0] IMAGE = rom_image(WIDTH);

    logic [11:0] base;

    assign base = 12'(RADDR) * 12'(WIDTH);

    // Read enable and clock enable are permanently on; no write port.
    always_ff @(posedge CLKIN) begin
        RDATA <= IMAGE[base +: WIDTH];
    end

endmodule

// File: rtl/rom_burst_reader.sv
// Streams LEN_M1+1 consecutive ROM words from START_ADDR over valid/ready.
// A 2-entry FIFO plus read credit hides the one-cycle ROM latency.
module rom_burst_reader
    import rom_burst_pkg::*;
#(
    parameter int    WIDTH     = 16,
    parameter int    DEPTH     = 256,
    parameter string INIT_FILE = "",
    localparam int   AW        = $clog2(DEPTH)
) (
    input  logic             CLKIN,
    input  logic             RESET,
    input  logic             START,
    input  logic [AW-1:0]    START_ADDR,
    input  logic [AW-1:0]    LEN_M1,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RDATA,
    output logic             RVALID,
    input  logic             RREADY
);

    if (!geometry_ok(WIDTH, DEPTH)) begin : g_bad_geom
        $error("rom_burst_reader: unsupported WIDTH/DEPTH pair");
    end

    if (INIT_FILE != "") begin : g_no_file
        $error("rom_burst_reader: only the identity image is built in");
    end

    state_t state_q;
    state_t state_d;

    logic [AW-1:0]    addr_q;
    logic [AW-1:0]    rem_q;
    logic             inflight_q;
    logic             done_q;
    logic [WIDTH-1:0] fifo_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [WIDTH-1:0] rom_data;

    logic       accept;
    logic       issue;
    logic       push;
    logic       pop;
    logic       last_pop;
    logic [2:0] occ;

    rom_sync_4k #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_rom (
        .CLKIN (CLKIN),
        .RADDR (addr_q),
        .RDATA (rom_data)
    );

    assign RVALID = (count_q != 2'd0);
    assign RDATA  = RVALID ? fifo_q[rd_ptr_q] : '0;
    assign BUSY   = (state_q != IDLE);
    assign DONE   = done_q;

    assign pop  = RVALID & RREADY;
    assign push = inflight_q;

    // Words owned after this cycle: stored + arriving - leaving.
    assign occ = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};

    assign last_pop = (state_q == DRAIN) && pop
                   && (count_q == 2'd1) && !inflight_q;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        issue   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (START) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (occ < 3'd2) begin
                    issue = 1'b1;
                    if (rem_q == '0) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (last_pop) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLKIN) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLKIN) begin
        if (RESET) begin
            addr_q     <= '0;
            rem_q      <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            inflight_q <= issue;
            done_q     <= last_pop;
            if (accept) begin
                addr_q <= START_ADDR;
                rem_q  <= LEN_M1;
            end else if (issue) begin
                addr_q <= addr_q + 1'b1;
                rem_q  <= rem_q - 1'b1;
            end
        end
    end

    always_ff @(posedge CLKIN) begin
        if (RESET) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= rom_data;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(push) - 2'(pop);
        end
    end

endmodule
